// File: rtl/alu_sequencer.sv
// ALU micro-sequencer: one op per IDLE->EXEC->DONE pass, drives ALU
// control lines, captures the ALU return into result and flags.
module alu_sequencer (
  input  logic       clk,
  input  logic       nrst,
  input  logic       start,
  input  logic [3:0] op,
  input  logic       dec_mode,
  input  logic       c_flag,
  input  logic [7:0] alu_out,
  input  logic       alu_carry,
  input  logic       alu_overflow,
  output logic       lda_sb,
  output logic       lda_zero,
  output logic       ldb_db,
  output logic       ldb_inv_db,
  output logic       ldb_adl,
  output logic       e_sum,
  output logic       e_and,
  output logic       e_eor,
  output logic       e_or,
  output logic       e_shiftr,
  output logic       carry_in,
  output logic       enable_dec,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       wr_en,
  output logic [7:0] result,
  output logic       flag_c,
  output logic       flag_v,
  output logic       flag_z,
  output logic       flag_n
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_t;

  typedef struct packed {
    logic lda_sb;
    logic lda_zero;
    logic ldb_db;
    logic ldb_inv_db;
    logic ldb_adl;
    logic e_sum;
    logic e_and;
    logic e_eor;
    logic e_or;
    logic e_shiftr;
    logic carry_in;
    logic enable_dec;
  } ctrl_t;

  localparam logic [3:0] OP_ADC = 4'd0;
  localparam logic [3:0] OP_SBC = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_EOR = 4'd3;
  localparam logic [3:0] OP_ORA = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_ASL = 4'd7;
  localparam logic [3:0] OP_ROL = 4'd8;
  localparam logic [3:0] OP_INC = 4'd9;
  localparam logic [3:0] OP_CMP = 4'd10;

  // Controls are computed at the accepting edge from the live inputs,
  // so later input changes cannot disturb the op in flight.
  function automatic ctrl_t decode(
    input logic [3:0] o,
    input logic       c,
    input logic       d
  );
    ctrl_t k;
    k = '0;
    unique case (1'b1)
      (o == OP_ADC), (o == OP_SBC): begin
        k.lda_sb     = 1'b1;
        k.ldb_db     = (o == OP_ADC);
        k.ldb_inv_db = (o == OP_SBC);
        k.e_sum      = 1'b1;
        k.carry_in   = c;
        k.enable_dec = d;
      end
      (o == OP_AND), (o == OP_EOR), (o == OP_ORA): begin
        k.lda_sb = 1'b1;
        k.ldb_db = 1'b1;
        k.e_and  = (o == OP_AND);
        k.e_eor  = (o == OP_EOR);
        k.e_or   = (o == OP_ORA);
      end
      (o == OP_LSR), (o == OP_ROR): begin
        k.lda_sb   = 1'b1;
        k.e_shiftr = 1'b1;
        k.carry_in = (o == OP_ROR) & c;
      end
      (o == OP_ASL), (o == OP_ROL): begin
        k.lda_sb   = 1'b1;
        k.ldb_db   = 1'b1;
        k.e_sum    = 1'b1;
        k.carry_in = (o == OP_ROL) & c;
      end
      (o == OP_INC): begin
        k.lda_zero = 1'b1;
        k.ldb_db   = 1'b1;
        k.e_sum    = 1'b1;
        k.carry_in = 1'b1;
      end
      (o == OP_CMP): begin
        k.lda_sb     = 1'b1;
        k.ldb_inv_db = 1'b1;
        k.e_sum      = 1'b1;
        k.carry_in   = 1'b1;
      end
      default: ;
    endcase
    return k;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] op_q, op_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic [7:0] result_q, result_d;
  logic       flag_c_q, flag_c_d;
  logic       flag_v_q, flag_v_d;
  logic       flag_z_q, flag_z_d;
  logic       flag_n_q, flag_n_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       wr_en_q, wr_en_d;

  logic legal;
  logic upd_c;
  logic upd_v;

  assign legal = (op_q <= OP_CMP);
  assign upd_c = (op_q == OP_ADC) | (op_q == OP_SBC)
               | (op_q == OP_CMP) | (op_q == OP_LSR)
               | (op_q == OP_ROR) | (op_q == OP_ASL)
               | (op_q == OP_ROL);
  assign upd_v = (op_q == OP_ADC) | (op_q == OP_SBC);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ctrl_d   = '0;
    result_d = result_q;
    flag_c_d = flag_c_q;
    flag_v_d = flag_v_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    wr_en_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EXEC;
          op_d    = op;
          ctrl_d  = decode(op, c_flag, dec_mode);
          busy_d  = 1'b1;
        end
      end
      EXEC: begin
        state_d = DONE;
        done_d  = 1'b1;
        if (legal) begin
          flag_z_d = (alu_out == 8'h00);
          flag_n_d = alu_out[7];
          if (upd_c) flag_c_d = alu_carry;
          if (upd_v) flag_v_d = alu_overflow;
          if (op_q != OP_CMP) begin
            result_d = alu_out;
            wr_en_d  = 1'b1;
          end
        end else begin
          err_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      ctrl_q   <= '0;
      result_q <= '0;
      flag_c_q <= 1'b0;
      flag_v_q <= 1'b0;
      flag_z_q <= 1'b0;
      flag_n_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      wr_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      ctrl_q   <= ctrl_d;
      result_q <= result_d;
      flag_c_q <= flag_c_d;
      flag_v_q <= flag_v_d;
      flag_z_q <= flag_z_d;
      flag_n_q <= flag_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      wr_en_q  <= wr_en_d;
    end
  end

  assign lda_sb     = ctrl_q.lda_sb;
  assign lda_zero   = ctrl_q.lda_zero;
  assign ldb_db     = ctrl_q.ldb_db;
  assign ldb_inv_db = ctrl_q.ldb_inv_db;
  assign ldb_adl    = ctrl_q.ldb_adl;
  assign e_sum      = ctrl_q.e_sum;
  assign e_and      = ctrl_q.e_and;
  assign e_eor      = ctrl_q.e_eor;
  assign e_or       = ctrl_q.e_or;
  assign e_shiftr   = ctrl_q.e_shiftr;
  assign carry_in   = ctrl_q.carry_in;
  assign enable_dec = ctrl_q.enable_dec;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign wr_en      = wr_en_q;
  assign result     = result_q;
  assign flag_c     = flag_c_q;
  assign flag_v     = flag_v_q;
  assign flag_z     = flag_z_q;
  assign flag_n     = flag_n_q;

endmodule
